// File: rtl/periph_write_queue_pkg.sv
// Shared definitions for the peripheral write queue: sync register addresses,
// FSM state encoding and the default sync-wait timeout.
package periph_write_queue_pkg;

    localparam logic [7:0]  REG_WAIT_VBLANK = 8'h00;
    localparam logic [7:0]  REG_WAIT_HBLANK = 8'h02;
    localparam logic [19:0] DEFAULT_TIMEOUT = 20'hFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_GAP       = 3'd2,
        ST_SYNC_ARM  = 3'd3,
        ST_SYNC_WAIT = 3'd4
    } wq_state_e;

    // Full 8-bit compare: 0x80/0x82 alias nothing and must not stall.
    function automatic logic is_sync_reg(input logic [7:0] addr);
        return (addr == REG_WAIT_VBLANK) || (addr == REG_WAIT_HBLANK);
    endfunction

endpackage

// File: rtl/periph_write_queue_sync_fifo.sv
// Synchronous FIFO with occupancy counter; head entry is presented combinationally.
module periph_write_queue_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush overrides both sides; a push while full is dropped even if a pop frees a slot.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/periph_write_queue.sv
// Replays queued (address, data) pairs as one-cycle peripheral register writes,
// stalling after video-sync register writes until the responder releases wait_video.
module periph_write_queue
    import periph_write_queue_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          AW      = 4,
    parameter logic [19:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          raw_clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    push_address,
    input  logic [7:0]    push_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          overflow,
    output logic          sync_timeout,
    output logic [7:0]    bus_address,
    output logic [7:0]    bus_data,
    output logic          bus_write_enable,
    input  logic          wait_video,
    output logic [2:0]    dbg_state
);

    wq_state_e   state_q;
    logic [7:0]  bus_address_q;
    logic [7:0]  bus_data_q;
    logic        bus_we_q;
    logic [19:0] count_q;
    logic [19:0] count_d;
    logic        overflow_q;
    logic        sync_timeout_q;
    logic [15:0] head;
    logic        fifo_pop;

    periph_write_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (16)
    ) u_fifo (
        .clk_i   (raw_clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .wdata_i ({push_address, push_data}),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign fifo_pop = (state_q == ST_IDLE) && !empty && !flush;
    assign count_d  = (count_q == TIMEOUT) ? count_q : count_q + 20'd1;

    assign busy             = (state_q != ST_IDLE) || !empty;
    assign overflow         = overflow_q;
    assign sync_timeout     = sync_timeout_q;
    assign bus_address      = bus_address_q;
    assign bus_data         = bus_data_q;
    assign bus_write_enable = bus_we_q;
    assign dbg_state        = state_q;

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            bus_address_q  <= '0;
            bus_data_q     <= '0;
            bus_we_q       <= 1'b0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            sync_timeout_q <= 1'b0;
        end else if (flush) begin
            // Bus address/data keep their last values; only the strobe is cut.
            state_q        <= ST_IDLE;
            bus_we_q       <= 1'b0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            sync_timeout_q <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        bus_address_q <= head[15:8];
                        bus_data_q    <= head[7:0];
                        bus_we_q      <= 1'b1;
                        state_q       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    bus_we_q <= 1'b0;
                    state_q  <= is_sync_reg(bus_address_q) ? ST_SYNC_ARM : ST_GAP;
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                ST_SYNC_ARM: begin
                    count_q <= '0;
                    state_q <= ST_SYNC_WAIT;
                end
                ST_SYNC_WAIT: begin
                    count_q <= count_d;
                    if (!wait_video) begin
                        state_q <= ST_IDLE;
                    end else if (count_d == TIMEOUT) begin
                        sync_timeout_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_write_queue.sv
// Directed + randomized bench for periph_write_queue, checked against an
// occupancy/ordering model of the queue and the documented FSM timing.
module tb_periph_write_queue;
    import periph_write_queue_pkg::*;

    localparam int          DEPTH   = 16;
    localparam int          AW      = 4;
    localparam logic [19:0] TIMEOUT = 20'd100;

    logic          raw_clk;
    logic          reset_n;
    logic          push;
    logic [7:0]    push_address;
    logic [7:0]    push_data;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          busy;
    logic          overflow;
    logic          sync_timeout;
    logic [7:0]    bus_address;
    logic [7:0]    bus_data;
    logic          bus_write_enable;
    logic          wait_video;
    logic [2:0]    dbg_state;

    int            tests;
    int            failed;
    int            cyc;
    int            m_level;
    logic          m_ovf;
    logic          prev_we;
    logic [15:0]   exp_q[$];
    int            strobe_cyc[$];

    periph_write_queue #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .raw_clk          (raw_clk),
        .reset_n          (reset_n),
        .push             (push),
        .push_address     (push_address),
        .push_data        (push_data),
        .flush            (flush),
        .full             (full),
        .empty            (empty),
        .level            (level),
        .busy             (busy),
        .overflow         (overflow),
        .sync_timeout     (sync_timeout),
        .bus_address      (bus_address),
        .bus_data         (bus_data),
        .bus_write_enable (bus_write_enable),
        .wait_video       (wait_video),
        .dbg_state        (dbg_state)
    );

    initial begin
        raw_clk = 1'b0;
        forever #5 raw_clk = ~raw_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from inputs applied at this edge, then compare.
    task automatic tick();
        logic        acc;
        logic [15:0] e;
        acc = push && !flush && (m_level < DEPTH);
        if (flush) begin
            m_level = 0;
            exp_q.delete();
            m_ovf = 1'b0;
        end else if (push && !acc) begin
            m_ovf = 1'b1;
        end
        @(posedge raw_clk);
        #1;
        cyc++;
        if (bus_write_enable) begin
            check("strobe_width", 32'(prev_we), 32'd0);
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(bus_write_enable), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bus_address", 32'(bus_address), 32'(e[15:8]));
                check("bus_data", 32'(bus_data), 32'(e[7:0]));
                m_level--;
            end
        end
        if (acc) begin
            exp_q.push_back({push_address, push_data});
            m_level++;
        end
        prev_we = bus_write_enable;
        check("level", 32'(level), 32'(m_level));
        check("empty", 32'(empty), 32'(m_level == 0));
        check("full", 32'(full), 32'(m_level == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        prev_we = 1'b0;
    endtask

    task automatic do_reset();
        push = 1'b0; flush = 1'b0; wait_video = 1'b0;
        push_address = '0; push_data = '0;
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge raw_clk);
        @(negedge raw_clk);
        reset_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        push = 1'b0; flush = 1'b0; wait_video = 1'b0;
        n = 0;
        while ((busy || level != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic do_flush();
        flush = 1'b1; push = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    // Non-sync single write from an idle, empty queue with exact timing checks.
    task automatic single_write(input logic [7:0] a, input logic [7:0] d);
        push = 1'b1; push_address = a; push_data = d;
        tick();
        push = 1'b0;
        check("sw_no_strobe_yet", 32'(bus_write_enable), 32'd0);
        check("sw_level1", 32'(level), 32'd1);
        tick();
        check("sw_strobe", 32'(bus_write_enable), 32'd1);
        check("sw_addr", 32'(bus_address), 32'(a));
        check("sw_data", 32'(bus_data), 32'(d));
        check("sw_level0", 32'(level), 32'd0);
        tick();
        check("sw_strobe_off", 32'(bus_write_enable), 32'd0);
        check("sw_busy_gap", 32'(busy), 32'd1);
        tick();
        check("sw_busy_idle", 32'(busy), 32'd0);
        check("sw_addr_hold", 32'(bus_address), 32'(a));
        check("sw_data_hold", 32'(bus_data), 32'(d));
    endtask

    initial begin
        int n0;
        tests = 0; failed = 0; cyc = 0;
        reset_n = 1'b1;
        model_clear();

        // Reset state
        do_reset();
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(bus_write_enable), 32'd0);
        check("rst_addr", 32'(bus_address), 32'd0);
        check("rst_data", 32'(bus_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tmo", 32'(sync_timeout), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Test 1: single write latency and strobe width
        single_write(8'h09, 8'h42);

        // Test 2: hold FSM in SYNC_WAIT, overfill the queue
        wait_video = 1'b1;
        push = 1'b1; push_address = 8'h02; push_data = 8'h55;
        tick();
        push = 1'b0;
        repeat (3) tick();
        check("t2_sync_wait", 32'(dbg_state), 32'(ST_SYNC_WAIT));
        for (int i = 0; i < 17; i++) begin
            push = 1'b1; push_address = 8'h20 + 8'(i); push_data = 8'($urandom);
            tick();
        end
        push = 1'b0;
        check("t2_level16", 32'(level), 32'd16);
        check("t2_full", 32'(full), 32'd1);
        check("t2_overflow", 32'(overflow), 32'd1);
        drain(300);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        do_flush();
        check("t2_ovf_cleared", 32'(overflow), 32'd0);

        // Test 3: sync stall released by wait_video
        wait_video = 1'b1;
        push = 1'b1; push_address = 8'h02; push_data = 8'h00;
        tick();
        push_address = 8'h06; push_data = 8'h10;
        tick();
        push = 1'b0;
        check("t3_first_strobe", 32'(bus_write_enable), 32'd1);
        repeat (50) tick();
        check("t3_stalled", 32'(dbg_state), 32'(ST_SYNC_WAIT));
        check("t3_pending", 32'(level), 32'd1);
        wait_video = 1'b0;
        tick();
        check("t3_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("t3_no_strobe", 32'(bus_write_enable), 32'd0);
        tick();
        check("t3_second_strobe", 32'(bus_write_enable), 32'd1);
        check("t3_second_addr", 32'(bus_address), 32'h06);
        drain(50);

        // Test 4: sync wait timeout at cycle TIMEOUT, queue resumes
        wait_video = 1'b1;
        push = 1'b1; push_address = 8'h00; push_data = 8'h00;
        tick();
        push_address = 8'h05; push_data = 8'hAA;
        tick();
        push = 1'b0;
        check("t4_first_strobe", 32'(bus_write_enable), 32'd1);
        repeat (101) tick();
        check("t4_still_waiting", 32'(dbg_state), 32'(ST_SYNC_WAIT));
        check("t4_no_tmo_yet", 32'(sync_timeout), 32'd0);
        tick();
        check("t4_tmo", 32'(sync_timeout), 32'd1);
        check("t4_idle", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("t4_resume_strobe", 32'(bus_write_enable), 32'd1);
        check("t4_resume_addr", 32'(bus_address), 32'h05);
        repeat (3) tick();
        check("t4_tmo_sticky", 32'(sync_timeout), 32'd1);

        // Test 5: flush with simultaneous push mid-drain
        wait_video = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_address = 8'h10 + 8'(i); push_data = 8'($urandom);
            tick();
        end
        push = 1'b0;
        repeat (2) tick();
        flush = 1'b1; push = 1'b1; push_address = 8'h55; push_data = 8'h66;
        tick();
        flush = 1'b0; push = 1'b0;
        check("t5_level0", 32'(level), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_we0", 32'(bus_write_enable), 32'd0);
        check("t5_ovf0", 32'(overflow), 32'd0);
        check("t5_tmo0", 32'(sync_timeout), 32'd0);
        check("t5_idle", 32'(dbg_state), 32'(ST_IDLE));
        n0 = strobe_cyc.size();
        repeat (15) tick();
        check("t5_no_more_strobes", 32'(strobe_cyc.size()), 32'(n0));

        // Test 6: asynchronous reset during WRITE
        push = 1'b1; push_address = 8'h11; push_data = 8'h22;
        tick();
        push = 1'b0;
        tick();
        check("t6_in_write", 32'(bus_write_enable), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_we", 32'(bus_write_enable), 32'd0);
        check("t6_async_empty", 32'(empty), 32'd1);
        check("t6_async_state", 32'(dbg_state), 32'(ST_IDLE));
        model_clear();
        @(negedge raw_clk);
        reset_n = 1'b1;
        single_write(8'h33, 8'h44);

        // Non-sync addresses (0x80/0x82) never stall: strobes every 3 cycles
        wait_video = 1'b1;
        strobe_cyc.delete();
        push = 1'b1; push_address = 8'h80; push_data = 8'h01;
        tick();
        push_address = 8'h82; push_data = 8'h02;
        tick();
        push_address = 8'h01; push_data = 8'h03;
        tick();
        push = 1'b0;
        repeat (10) tick();
        check("ns_count", 32'(strobe_cyc.size()), 32'd3);
        if (strobe_cyc.size() == 3) begin
            check("ns_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd3);
            check("ns_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd3);
        end
        drain(50);

        // Randomized traffic against the ordering/occupancy model
        for (int i = 0; i < 600; i++) begin
            push = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       push_address = 8'h00;
                1:       push_address = 8'h02;
                2:       push_address = 8'h80;
                3:       push_address = 8'h82;
                default: push_address = 8'($urandom_range(0, 255));
            endcase
            push_data  = 8'($urandom);
            flush      = ($urandom_range(0, 59) == 0);
            wait_video = ($urandom_range(0, 9) < 6);
            tick();
        end
        flush = 1'b0;
        drain(500);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
